// File: rtl/call_stack_pkg.sv
// Shared definitions for the call stack: stack-op encoding and the level-width helper
// used by both the pointer and the return-stack top level.
package call_stack_pkg;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_REPL = 2'd3
  } stack_op_e;

  // Width needed to count 0..depth entries inclusive.
  function automatic int nlvl_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/call_stack_ptr.sv
// Modulo-DEPTH top-of-stack pointer; exposes the current index and both wrapped neighbours.
module call_stack_ptr
  import call_stack_pkg::*;
#(
  parameter int DEPTH = 5,
  parameter int NADDR = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  stack_op_e        op,
  output logic [NADDR-1:0] tp,
  output logic [NADDR-1:0] tp_up,
  output logic [NADDR-1:0] tp_dn
);

  localparam logic [NADDR-1:0] TOP_IDX = NADDR'(DEPTH - 1);

  logic [NADDR-1:0] tp_q, tp_d;

  // NOTE: combinational logic uses blocking '=' with a default first, so no latch is inferred.
  always_comb begin
    tp_up = (tp_q == TOP_IDX) ? '0 : tp_q + NADDR'(1);
    tp_dn = (tp_q == '0) ? TOP_IDX : tp_q - NADDR'(1);
    tp_d  = tp_q;
    case (op)
      OP_PUSH: tp_d = tp_up;
      OP_POP:  tp_d = tp_dn;
      default: tp_d = tp_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) tp_q <= TOP_IDX;  // first push lands at index 0
    else     tp_q <= tp_d;
  end

  assign tp = tp_q;

endmodule

// File: rtl/call_stack.sv
// Circular-buffer return-address stack with registered top-of-stack output.
// Optional macro CALL_STACK_GUARD_EN: drop pushes when full and raise sticky ovf/unf flags.
module call_stack
  import call_stack_pkg::*;
#(
  parameter int NBITS = 9,
  parameter int DEPTH = 5,
  localparam int NADDR = $clog2(DEPTH),
  localparam int NLVL  = nlvl_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [NBITS-1:0] in,
  output logic [NBITS-1:0] out,
  output logic [NLVL-1:0]  level,
  output logic             full,
  output logic             empty,
  output logic             ovf,
  output logic             unf,
  input  logic             clr_err
);

  logic [NBITS-1:0] mem_q [DEPTH];
  logic [NBITS-1:0] out_q, out_d;
  logic [NLVL-1:0]  level_q, level_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             ovf_set, unf_set;
  logic             wr_en;
  logic [NADDR-1:0] wr_idx, tp, tp_up, tp_dn;
  stack_op_e        op;

  assign empty = (level_q == '0);
  assign full  = (level_q == NLVL'(DEPTH));

  // Decode the request into a single stack operation; push+pop on empty acts as a push.
  always_comb begin
    op      = OP_NONE;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (push && (!pop || empty)) begin
`ifdef CALL_STACK_GUARD_EN
      if (full) ovf_set = 1'b1;
      else      op      = OP_PUSH;
`else
      op = OP_PUSH;
`endif
    end else if (push && pop) begin
      op = OP_REPL;
    end else if (pop) begin
      if (!empty) op      = OP_POP;
      else        unf_set = 1'b1;
    end
  end

  call_stack_ptr #(.DEPTH(DEPTH), .NADDR(NADDR)) u_ptr (
    .clk   (clk),
    .rst   (rst),
    .op    (op),
    .tp    (tp),
    .tp_up (tp_up),
    .tp_dn (tp_dn)
  );

  always_comb begin
    level_d = level_q;
    out_d   = out_q;
    wr_en   = 1'b0;
    wr_idx  = tp;
    case (op)
      OP_PUSH: begin
        wr_en  = 1'b1;
        wr_idx = tp_up;
        out_d  = in;
        if (!full) level_d = level_q + NLVL'(1);  // full push overwrites the oldest entry
      end
      OP_REPL: begin
        wr_en = 1'b1;
        out_d = in;
      end
      OP_POP: begin
        level_d = level_q - NLVL'(1);
        out_d   = (level_q == NLVL'(1)) ? '0 : mem_q[tp_dn];
      end
      default: ;
    endcase
  end

`ifdef CALL_STACK_GUARD_EN
  // Same-cycle error event wins over clr_err.
  assign ovf_d = ovf_set | (ovf_q & ~clr_err);
  assign unf_d = unf_set | (unf_q & ~clr_err);
`else
  logic [2:0] unused_err;
  assign unused_err = {ovf_set, unf_set, clr_err};
  assign ovf_d = 1'b0;
  assign unf_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= '0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // NOTE: storage array has no reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem_q[wr_idx] <= in;
  end

  assign out   = out_q;
  assign level = level_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule

// File: doc/call_stack.md
CALL_STACK -- requirements
Module: call_stack

Interface
REQ-001 SHALL have parameter NBITS, default 9, meaning return-address width.
REQ-002 SHALL have parameter DEPTH, default 5, meaning number of entries (any value >= 2, not limited to powers of two).
REQ-003 SHALL have derived localparam NADDR = $clog2(DEPTH) and NLVL = $clog2(DEPTH+1).
REQ-004 SHALL have port clk, input, 1, system clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-006 SHALL have port push, input, 1, write `in` as new top.
REQ-007 SHALL have port pop, input, 1, discard top.
REQ-008 SHALL have port in, input, NBITS, address to push.
REQ-009 SHALL have port out, output, NBITS, registered top-of-stack.
REQ-010 SHALL have port level, output, NLVL, current entry count 0..DEPTH.
REQ-011 SHALL have ports full and empty, output, 1 each, combinational decodes: level==DEPTH and level==0.
REQ-012 SHALL have ports ovf and unf, output, 1 each, sticky overflow and underflow error flags.
REQ-013 SHALL have port clr_err, input, 1, clears ovf and unf.

Function
REQ-014 SHALL hold entries in a circular buffer indexed by top pointer tp, with wrap modulo DEPTH both ways.
REQ-015 push only, not full: tp <= tp+1 (wrapped); mem[tp+1] <= in; level +1; out <= in.
REQ-016 pop only, not empty: tp <= tp-1 (wrapped); level -1; out <= mem[tp-1], or 0 if new level is 0.
REQ-017 push and pop together, not empty: replace top, i.e. mem[tp] <= in, out <= in, tp and level unchanged (tail-call case).
REQ-018 push and pop together, empty: SHALL behave as push only.
REQ-019 neither push nor pop: SHALL leave all state unchanged.
REQ-020 out SHALL reflect the completed operation one cycle after the push or pop edge, giving latency 1.
REQ-021 pop when empty: SHALL not change tp, level or out.
REQ-022 push when full: behaviour is set by REQ-027 and REQ-028.
REQ-023 clr_err SHALL clear ovf and unf on the next edge; a same-cycle error event SHALL win over clr_err.

Reset
REQ-024 rst SHALL set tp = DEPTH-1 (so the first push lands at index 0), level = 0, out = 0, ovf = 0, unf = 0.
REQ-025 rst SHALL take priority over push, pop and clr_err, including when asserted mid-sequence; mem contents are not cleared.

Configuration
REQ-026 The only macro is CALL_STACK_GUARD_EN.
REQ-027 With CALL_STACK_GUARD_EN defined:
- push-only when full is dropped, with no state change except ovf <= 1.
- pop when empty sets unf <= 1.
REQ-028 Without CALL_STACK_GUARD_EN:
- push-only when full overwrites the oldest entry (tp wraps, level stays DEPTH, out <= in).
- ovf and unf are tied to 0 and clr_err is ignored.

Structure
REQ-029 A shared core package/header SHALL hold the stack-op encoding constants (NONE, PUSH, POP, REPL) and the NLVL width function, so the stack pointer and return stack use them consistently.
REQ-030 A single sub-module, call_stack_ptr, SHALL implement the modulo-DEPTH up/down pointer with wrap; the top level holds mem, level, out and the flags.

Verification (DEPTH=5, NBITS=9)
REQ-031 Reset, then push 0x011, 0x022, 0x033 on consecutive cycles -> out=0x011, 0x022, 0x033, each one cycle after its push; level=3.
REQ-032 Continuing from REQ-031, pop x3 -> out=0x022, 0x011, 0x000; level=0; empty=1.
REQ-033 push 0x0AA, then push+pop with in=0x0BB -> out=0x0BB, level=1; then pop -> empty=1, out=0.
REQ-034 Six pushes of 1..6:
- With guard: level=5, full=1, out=5, ovf=1; then clr_err -> ovf=0.
- Without guard: out=6, level=5; popping 5 times yields 5, 4, 3, 2 in sequence and ends empty.
REQ-035 pop on empty -> level=0, out=0, and unf=1 with guard / unf=0 without.
REQ-036 push 0x055 twice, then assert rst together with push -> level=0, out=0, flags=0; the next push of 0x077 -> out=0x077, level=1.
